// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared instruction-set definitions for the 27-bit instruction word.
// The field layout is used by instruction_register (splits the word),
// instruction_encoder / program_loader (builds the word) and the control unit.
//
//   [26:23] opcode   [22:18] rd   [17:13] rs1   [12:8] rs2   [7:0] immediate
// ---------------------------------------------------------------------------
package isa_pkg;

    // Field widths
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 8;
    localparam int unsigned INSTR_W  = 27;

    // Field LSB positions inside the instruction word
    localparam int unsigned OPCODE_LSB = 23;
    localparam int unsigned RD_LSB     = 18;
    localparam int unsigned RS1_LSB    = 13;
    localparam int unsigned RS2_LSB    = 8;
    localparam int unsigned IMM_LSB    = 0;

    // Opcodes understood by the multicycle core
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_ADDI = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

endpackage

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
// Purely combinational packer: places the five instruction fields at their
// positions in a 27-bit word. It is the exact inverse of the field split done
// by instruction_register.
//
// Ports:
//   opcode_i  in   4   opcode field
//   rd_i      in   5   destination register
//   rs1_i     in   5   first source register
//   rs2_i     in   5   second source register
//   imm_i     in   8   immediate
//   instr_o   out  27  packed instruction word
// ---------------------------------------------------------------------------
module instruction_encoder
    import isa_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [REG_W-1:0]    rd_i,
    input  logic [REG_W-1:0]    rs1_i,
    input  logic [REG_W-1:0]    rs2_i,
    input  logic [IMM_W-1:0]    imm_i,
    output logic [INSTR_W-1:0]  instr_o
);

    // Drop each field into its slot; the slots tile the whole word, so the
    // zero default is only there to keep the block obviously latch-free.
    always_comb begin
        instr_o = '0;
        instr_o[OPCODE_LSB +: OPCODE_W] = opcode_i;
        instr_o[RD_LSB     +: REG_W]    = rd_i;
        instr_o[RS1_LSB    +: REG_W]    = rs1_i;
        instr_o[RS2_LSB    +: REG_W]    = rs2_i;
        instr_o[IMM_LSB    +: IMM_W]    = imm_i;
    end

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Packs instruction fields into 27-bit words and streams them into
// instruction memory at consecutive addresses starting from 0. The CPU is
// held in reset (cpu_hold) until a HALT instruction has been written, so a
// whole program is in place before the core starts fetching.
//
// Ports:
//   clk           in   1             rising-edge clock
//   reset         in   1             synchronous, active-high
//   start         in   1             pulse that begins a (re)load
//   opcode        in   4             field to pack
//   reg_dest      in   5             field to pack
//   reg_source_1  in   5             field to pack
//   reg_source_2  in   5             field to pack
//   immediate     in   8             field to pack
//   in_valid      in   1             fields are valid
//   in_ready      out  1             loader accepts fields (decoded from state)
//   mem_we        out  1             memory write strobe, one cycle per word
//   mem_addr      out  ADDR_WIDTH    write address
//   mem_data      out  27            packed instruction word
//   cpu_hold      out  1             keeps the CPU in reset while high
//   done          out  1             load finished with HALT
//   overflow      out  1             memory filled without a HALT
//   word_count    out  ADDR_WIDTH+1  words written in the current load
// ---------------------------------------------------------------------------
module program_loader
    import isa_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 8,
    parameter int              MEM_DEPTH   = 256,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = OP_HALT
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [REG_W-1:0]      reg_dest,
    input  logic [REG_W-1:0]      reg_source_1,
    input  logic [REG_W-1:0]      reg_source_2,
    input  logic [IMM_W-1:0]      immediate,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [INSTR_W-1:0]    mem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    // word_count is one bit wider than the address so a full memory can be
    // counted; the last legal address is compared at that width.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [1:0]            state_q,      state_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  mem_we_q,     mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [INSTR_W-1:0]    mem_data_q,   mem_data_d;
    logic                  cpu_hold_q,   cpu_hold_d;
    logic                  done_q,       done_d;
    logic                  overflow_q,   overflow_d;

    logic [INSTR_W-1:0]    encodedWord;
    logic                  transfer;

    instruction_encoder u_encoder (
        .opcode_i (opcode),
        .rd_i     (reg_dest),
        .rs1_i    (reg_source_1),
        .rs2_i    (reg_source_2),
        .imm_i    (immediate),
        .instr_o  (encodedWord)
    );

    // in_ready is the only output not taken from a register; the source
    // sees it in the same cycle the state enters LOAD.
    assign in_ready = (state_q == ST_LOAD);
    assign transfer = in_valid && in_ready;

    // Next-state logic. mem_we defaults low every cycle so a write strobe
    // lasts exactly one cycle after its accepting edge. start is honoured
    // from IDLE, DONE and ERROR alike and always restarts at address 0.
    // A HALT is checked before the last-address test so a HALT landing in
    // the final slot still ends in DONE.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = done_q;
        overflow_d   = overflow_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                    cpu_hold_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (transfer) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[ADDR_WIDTH-1:0];
                    mem_data_d   = encodedWord;
                    word_count_d = word_count_q + COUNT_ONE;
                    if (opcode == HALT_OPCODE) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (word_count_q == LAST_ADDR) begin
                        state_d    = ST_ERROR;
                        overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset wins over everything, including a
    // start or a transfer on the same edge, and drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Two loaders share clock, reset and field inputs: dut0 has a full 256-word
// memory, dut1 only 4 words so the overflow and HALT-in-last-slot cases are
// reachable. Every expected write is queued when its word is offered and
// compared (address, data, and the edge it must appear on) when mem_we fires.
// ---------------------------------------------------------------------------
module tb_program_loader;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [7:0]  imm;
        logic [26:0] expData;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [26:0] data;
        int          edgeNo;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  startV;
    logic [1:0]  validV;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [7:0]  imm;

    logic [1:0]  inReady;
    logic [1:0]  memWe;
    logic [1:0]  cpuHold;
    logic [1:0]  doneV;
    logic [1:0]  overflowV;
    logic [7:0]  memAddr   [2];
    logic [26:0] memData   [2];
    logic [8:0]  wordCount [2];

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;
    int expAddr [2];
    wr_t expQA[$];
    wr_t expQB[$];

    vec_t basicVec [3];
    vec_t gapVec   [5];

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    program_loader #(.ADDR_WIDTH(8), .MEM_DEPTH(256), .HALT_OPCODE(4'hF)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .start        (startV[0]),
        .opcode       (op),
        .reg_dest     (rd),
        .reg_source_1 (rs1),
        .reg_source_2 (rs2),
        .immediate    (imm),
        .in_valid     (validV[0]),
        .in_ready     (inReady[0]),
        .mem_we       (memWe[0]),
        .mem_addr     (memAddr[0]),
        .mem_data     (memData[0]),
        .cpu_hold     (cpuHold[0]),
        .done         (doneV[0]),
        .overflow     (overflowV[0]),
        .word_count   (wordCount[0])
    );

    program_loader #(.ADDR_WIDTH(8), .MEM_DEPTH(4), .HALT_OPCODE(4'hF)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (startV[1]),
        .opcode       (op),
        .reg_dest     (rd),
        .reg_source_1 (rs1),
        .reg_source_2 (rs2),
        .immediate    (imm),
        .in_valid     (validV[1]),
        .in_ready     (inReady[1]),
        .mem_we       (memWe[1]),
        .mem_addr     (memAddr[1]),
        .mem_data     (memData[1]),
        .cpu_hold     (cpuHold[1]),
        .done         (doneV[1]),
        .overflow     (overflowV[1]),
        .word_count   (wordCount[1])
    );

    function automatic vec_t mkVec(input logic [3:0] o, input logic [4:0] d,
                                   input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [7:0] i, input logic [26:0] e);
        vec_t v;
        v.op = o; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = i; v.expData = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Pops the oldest queued write for a DUT and compares it with what the
    // DUT is presenting; a strobe with nothing queued is itself a failure.
    task automatic checkWrite(input int d);
        wr_t e;
        if ((d == 0 && expQA.size() == 0) || (d == 1 && expQB.size() == 0)) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedWrite dut%0d: got write addr=0x%0h data=0x%0h, required no write (t=%0t)",
                     d, memAddr[d], memData[d], $time);
            return;
        end
        if (d == 0) e = expQA.pop_front();
        else        e = expQB.pop_front();
        checkOutput($sformatf("writeAddr dut%0d", d), {24'd0, memAddr[d]}, {24'd0, e.addr});
        checkOutput($sformatf("writeData dut%0d", d), {5'd0, memData[d]}, {5'd0, e.data});
        checkOutput($sformatf("writeEdge dut%0d", d), cycleNo, e.edgeNo);
    endtask

    always @(negedge clk) begin
        if (memWe[0] === 1'b1) checkWrite(0);
        if (memWe[1] === 1'b1) checkWrite(1);
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input int d);
        startV[d] = 1'b1;
        align();
        startV[d] = 1'b0;
    endtask

    // Offers one word for a single cycle; the DUT must be ready, so the
    // write is queued for the accepting edge and the next address.
    task automatic applyStimulus(input int d, input vec_t v);
        wr_t e;
        op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        validV[d] = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("inReadyBeforeAccept dut%0d", d), {31'd0, inReady[d]}, 32'd1);
        e.addr   = 8'(expAddr[d]);
        e.data   = v.expData;
        e.edgeNo = cycleNo + 1;
        if (d == 0) expQA.push_back(e);
        else        expQB.push_back(e);
        expAddr[d]++;
        align();
        validV[d] = 1'b0;
    endtask

    task automatic checkResetState(input int d);
        checkOutput($sformatf("rstMemWe dut%0d", d),     {31'd0, memWe[d]},     32'd0);
        checkOutput($sformatf("rstInReady dut%0d", d),   {31'd0, inReady[d]},   32'd0);
        checkOutput($sformatf("rstCpuHold dut%0d", d),   {31'd0, cpuHold[d]},   32'd1);
        checkOutput($sformatf("rstDone dut%0d", d),      {31'd0, doneV[d]},     32'd0);
        checkOutput($sformatf("rstOverflow dut%0d", d),  {31'd0, overflowV[d]}, 32'd0);
        checkOutput($sformatf("rstWordCount dut%0d", d), {23'd0, wordCount[d]}, 32'd0);
        checkOutput($sformatf("rstMemAddr dut%0d", d),   {24'd0, memAddr[d]},   32'd0);
        checkOutput($sformatf("rstMemData dut%0d", d),   {5'd0, memData[d]},    32'd0);
    endtask

    task automatic checkStatus(input string tag, input int d, input logic rdy,
                               input logic hold, input logic dn, input logic ovf,
                               input int cnt);
        checkOutput({tag, $sformatf(" inReady dut%0d", d)},   {31'd0, inReady[d]},   {31'd0, rdy});
        checkOutput({tag, $sformatf(" cpuHold dut%0d", d)},   {31'd0, cpuHold[d]},   {31'd0, hold});
        checkOutput({tag, $sformatf(" done dut%0d", d)},      {31'd0, doneV[d]},     {31'd0, dn});
        checkOutput({tag, $sformatf(" overflow dut%0d", d)},  {31'd0, overflowV[d]}, {31'd0, ovf});
        checkOutput({tag, $sformatf(" wordCount dut%0d", d)}, {23'd0, wordCount[d]}, 32'(cnt));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        startV = 2'b00;
        validV = 2'b00;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        expAddr[0] = 0;
        expAddr[1] = 0;

        basicVec[0] = mkVec(4'h3, 5'h00, 5'h00, 5'h0A, 8'hAA, 27'h1800AAA);
        basicVec[1] = mkVec(4'h1, 5'h02, 5'h03, 5'h04, 8'h00, 27'h0886400);
        basicVec[2] = mkVec(4'hF, 5'h00, 5'h00, 5'h00, 8'h00, 27'h7800000);

        gapVec[0] = mkVec(4'h2, 5'h1F, 5'h00, 5'h1F, 8'h55, 27'h17C1F55);
        gapVec[1] = mkVec(4'h7, 5'h01, 5'h1F, 5'h00, 8'hFF, 27'h387E0FF);
        gapVec[2] = mkVec(4'hE, 5'h10, 5'h15, 5'h0A, 8'h01, 27'h742AA01);
        gapVec[3] = mkVec(4'h3, 5'h00, 5'h00, 5'h0A, 8'hAA, 27'h1800AAA);
        gapVec[4] = mkVec(4'hF, 5'h03, 5'h00, 5'h00, 8'h12, 27'h78C0012);

        // Reset held for two edges
        align();
        align();
        @(negedge clk);
        checkResetState(0);
        checkResetState(1);
        align();
        reset = 1'b0;

        // Basic three-word load ending in HALT
        $display("[TB] basic load");
        pulseStart(0);
        for (int i = 0; i < 3; i++) applyStimulus(0, basicVec[i]);
        @(negedge clk);
        checkStatus("basicEnd", 0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        align();

        // Reload from DONE
        $display("[TB] reload from done");
        pulseStart(0);
        expAddr[0] = 0;
        @(negedge clk);
        checkStatus("reload", 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        align();

        // Stream with a four-cycle gap; a start inside LOAD must be ignored
        $display("[TB] gapped stream");
        applyStimulus(0, gapVec[0]);
        applyStimulus(0, gapVec[1]);
        startV[0] = 1'b1;
        align();
        startV[0] = 1'b0;
        repeat (3) align();
        @(negedge clk);
        checkStatus("gapMid", 0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        align();
        for (int i = 2; i < 5; i++) applyStimulus(0, gapVec[i]);
        @(negedge clk);
        checkStatus("gapEnd", 0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        align();

        // Reset after two accepts, then reset together with start
        $display("[TB] reset mid-load");
        pulseStart(0);
        expAddr[0] = 0;
        applyStimulus(0, gapVec[0]);
        applyStimulus(0, gapVec[1]);
        reset = 1'b1;
        align();
        @(negedge clk);
        checkResetState(0);
        startV[0] = 1'b1;
        align();
        startV[0] = 1'b0;
        @(negedge clk);
        checkStatus("resetBeatsStart", 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        align();
        reset = 1'b0;
        pulseStart(0);
        expAddr[0] = 0;
        applyStimulus(0, basicVec[0]);
        applyStimulus(0, gapVec[4]);
        @(negedge clk);
        checkStatus("afterReset", 0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        align();

        // Four-word memory filled without HALT
        $display("[TB] overflow");
        pulseStart(1);
        expAddr[1] = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1, gapVec[i]);
        @(negedge clk);
        checkStatus("overflow", 1, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        align();
        validV[1] = 1'b1;
        repeat (2) align();
        validV[1] = 1'b0;
        @(negedge clk);
        checkStatus("errorHold", 1, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        align();

        // Restart from ERROR, HALT lands in the last slot
        $display("[TB] halt in last slot");
        pulseStart(1);
        expAddr[1] = 0;
        @(negedge clk);
        checkStatus("restartErr", 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        align();
        for (int i = 0; i < 3; i++) applyStimulus(1, gapVec[i]);
        applyStimulus(1, gapVec[4]);
        @(negedge clk);
        checkStatus("haltLast", 1, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        align();

        repeat (3) align();
        checkOutput("pendingWrites dut0", expQA.size(), 32'd0);
        checkOutput("pendingWrites dut1", expQB.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
